// File: rtl/gray_pkg.sv
// Gray/binary conversion helpers and decoder state encoding, shared with the
// encoder-side Gray counter.
package gray_pkg;

   localparam int GRAY_MAX_W = 32;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_TRACK = 1'b1
   } state_t;

   // Zero-extended inputs decode correctly for any width up to GRAY_MAX_W.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/gray_step_decoder_sync_bus.sv
// Multi-flop synchroniser for a Gray-coded bus; plain flop chain, no logic
// between stages so only one bit can be in flight per code change.
module sync_bus #(
   parameter int WIDTH       = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_chain [SYNC_STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_chain[i] <= '0;
      end else begin
         r_chain[0] <= i_d;
         for (int i = 1; i < SYNC_STAGES; i++) r_chain[i] <= r_chain[i-1];
      end
   end

   assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/gray_step_decoder.sv
// Synchronises a Gray-coded bus, decodes it to binary, classifies each change
// as up/down/illegal and keeps a wrapping position count.
module gray_step_decoder
   import gray_pkg::*;
#(
   parameter int WIDTH       = 3,
   parameter int SYNC_STAGES = 2,
   parameter int POS_WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     gray_in,
   input  logic                 clear,
   output logic [WIDTH-1:0]     bin_out,
   output logic                 step,
   output logic                 dir,
   output logic [POS_WIDTH-1:0] position,
   output logic                 err,
   output logic                 err_sticky
);

   logic [WIDTH-1:0]      w_g_s;
   logic [WIDTH-1:0]      w_diff;
   logic [GRAY_MAX_W-1:0] w_bin_new_full;
   logic [GRAY_MAX_W-1:0] w_bin_prev_full;
   logic [WIDTH-1:0]      w_bin_new;
   logic [WIDTH-1:0]      w_bin_prev;
   logic                  w_one_flip;
   logic                  w_multi_flip;
   logic                  w_is_up;

   state_t                r_state;
   logic [WIDTH-1:0]      r_prev;
   logic [WIDTH-1:0]      r_bin;
   logic                  r_step;
   logic                  r_dir;
   logic [POS_WIDTH-1:0]  r_pos;
   logic                  r_err;
   logic                  r_sticky;

   sync_bus #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst),
      .i_d   (gray_in),
      .o_q   (w_g_s)
   );

   assign w_bin_new_full  = gray2bin(GRAY_MAX_W'(w_g_s));
   assign w_bin_prev_full = gray2bin(GRAY_MAX_W'(r_prev));
   assign w_bin_new       = w_bin_new_full[WIDTH-1:0];
   assign w_bin_prev      = w_bin_prev_full[WIDTH-1:0];

   // Exactly one bit set <=> non-zero and clearing the lowest set bit leaves zero.
   assign w_diff       = w_g_s ^ r_prev;
   assign w_one_flip   = (w_diff != '0) && ((w_diff & (w_diff - WIDTH'(1))) == '0);
   assign w_multi_flip = (w_diff != '0) && !w_one_flip;
   assign w_is_up      = (w_bin_new == w_bin_prev + WIDTH'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_INIT;
         r_prev   <= '0;
         r_bin    <= '0;
         r_step   <= 1'b0;
         r_dir    <= 1'b1;
         r_pos    <= '0;
         r_err    <= 1'b0;
         r_sticky <= 1'b0;
      end else begin
         r_step <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_INIT: begin
               r_prev  <= w_g_s;
               r_bin   <= w_bin_new;
               r_state <= ST_TRACK;
            end
            ST_TRACK: begin
               if (w_one_flip) begin
                  r_prev <= w_g_s;
                  r_bin  <= w_bin_new;
                  r_step <= 1'b1;
                  r_dir  <= w_is_up;
                  r_pos  <= w_is_up ? r_pos + POS_WIDTH'(1) : r_pos - POS_WIDTH'(1);
               end else if (w_multi_flip) begin
                  // Re-baseline on the new code so one glitch yields one error.
                  r_prev   <= w_g_s;
                  r_bin    <= w_bin_new;
                  r_err    <= 1'b1;
                  r_sticky <= 1'b1;
               end
            end
            default: r_state <= ST_INIT;
         endcase
         // clear overrides the position update; a coincident error keeps the sticky flag.
         if (clear) begin
            r_pos <= '0;
            if (!(r_state == ST_TRACK && w_multi_flip)) r_sticky <= 1'b0;
         end
      end
   end

   assign bin_out    = r_bin;
   assign step       = r_step;
   assign dir        = r_dir;
   assign position   = r_pos;
   assign err        = r_err;
   assign err_sticky = r_sticky;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Directed bench for gray_step_decoder: a table-lookup reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_gray_step_decoder;

   localparam int WIDTH       = 3;
   localparam int SYNC_STAGES = 2;
   localparam int POS_WIDTH   = 8;
   localparam int NCODES      = 1 << WIDTH;
   localparam int NPOS        = 1 << POS_WIDTH;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [WIDTH-1:0]     gray_in;
   logic                 clear;
   logic [WIDTH-1:0]     bin_out;
   logic                 step;
   logic                 dir;
   logic [POS_WIDTH-1:0] position;
   logic                 err;
   logic                 err_sticky;

   int n_vec = 0;
   int n_bad = 0;

   gray_step_decoder #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .POS_WIDTH   (POS_WIDTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .gray_in    (gray_in),
      .clear      (clear),
      .bin_out    (bin_out),
      .step       (step),
      .dir        (dir),
      .position   (position),
      .err        (err),
      .err_sticky (err_sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Decode by searching the code table: binary i has Gray code i ^ (i >> 1).
   function automatic int decode(input int g);
      for (int i = 0; i < NCODES; i++) begin
         if ((i ^ (i >> 1)) == g) return i;
      end
      return -1;
   endfunction

   int  m_pipe [SYNC_STAGES];
   int  m_prev, m_bin, m_pos;
   bit  m_base, m_step, m_dir, m_err, m_stk;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) m_pipe[i] = 0;
         m_prev = 0; m_bin = 0; m_pos = 0; m_base = 0;
         m_step = 0; m_dir = 1; m_err = 0; m_stk = 0;
      end else begin
         int gs, flips, nb;
         gs = m_pipe[SYNC_STAGES-1];
         m_step = 0;
         m_err  = 0;
         if (!m_base) begin
            m_prev = gs;
            m_bin  = decode(gs);
            m_base = 1;
         end else begin
            flips = $countones(gs ^ m_prev);
            nb    = decode(gs);
            if (flips == 1) begin
               m_step = 1;
               if (nb == (decode(m_prev) + 1) % NCODES) begin
                  m_dir = 1;
                  m_pos = (m_pos + 1) % NPOS;
               end else begin
                  m_dir = 0;
                  m_pos = (m_pos + NPOS - 1) % NPOS;
               end
               m_prev = gs;
               m_bin  = nb;
            end else if (flips >= 2) begin
               m_err  = 1;
               m_stk  = 1;
               m_prev = gs;
               m_bin  = nb;
            end
         end
         if (clear) begin
            m_pos = 0;
            if (!m_err) m_stk = 0;
         end
         for (int i = SYNC_STAGES - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
         m_pipe[0] = int'(gray_in);
      end
   end

   always @(negedge clk) begin
      chk("bin_out",    32'(bin_out),    32'(m_bin));
      chk("step",       32'(step),       32'(m_step));
      chk("dir",        32'(dir),        32'(m_dir));
      chk("position",   32'(position),   32'(m_pos));
      chk("err",        32'(err),        32'(m_err));
      chk("err_sticky", 32'(err_sticky), 32'(m_stk));
      if (step && err) chk("step_err_excl", 32'(1), 32'(0));
   end

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic [WIDTH-1:0] g);
      gray_in = g;
      hold(4);
   endtask

   // Apply a code and assert clear on exactly the edge where its result registers.
   task automatic drive_with_clear(input logic [WIDTH-1:0] g);
      gray_in = g;
      hold(2);
      clear = 1'b1;
      hold(1);
      clear = 1'b0;
   endtask

   logic [WIDTH-1:0] up_codes [8] = '{3'b011, 3'b010, 3'b110, 3'b111,
                                      3'b101, 3'b100, 3'b000, 3'b001};
   logic [WIDTH-1:0] dn_codes [8] = '{3'b100, 3'b101, 3'b111, 3'b110,
                                      3'b010, 3'b011, 3'b001, 3'b000};

   initial begin
      rst     = 1'b0;
      gray_in = 3'b000;
      clear   = 1'b0;
      hold(3);
      chk("rst_bin",    32'(bin_out),  32'd0);
      chk("rst_dir",    32'(dir),      32'd1);
      chk("rst_pos",    32'(position), 32'd0);
      rst = 1'b1;
      hold(4);
      chk("init_step",  32'(step),     32'd0);
      chk("init_err",   32'(err),      32'd0);
      chk("init_pos",   32'(position), 32'd0);

      // Up sequence; the first code checks the exact output latency.
      gray_in = 3'b001;
      hold(2);
      chk("lat_early_step", 32'(step),    32'd0);
      hold(1);
      chk("lat_step",       32'(step),    32'd1);
      chk("lat_bin",        32'(bin_out), 32'd1);
      hold(1);
      for (int i = 0; i < 7; i++) drive(up_codes[i]);
      chk("up_pos",    32'(position),   32'd8);
      chk("up_bin",    32'(bin_out),    32'd0);
      chk("up_dir",    32'(dir),        32'd1);
      chk("up_sticky", 32'(err_sticky), 32'd0);

      clear = 1'b1;
      hold(1);
      clear = 1'b0;
      hold(1);
      chk("clr_pos", 32'(position), 32'd0);

      for (int i = 0; i < 8; i++) drive(dn_codes[i]);
      chk("dn_pos",    32'(position),   32'd248);
      chk("dn_dir",    32'(dir),        32'd0);
      chk("dn_sticky", 32'(err_sticky), 32'd0);

      drive(3'b011);
      chk("ill_sticky", 32'(err_sticky), 32'd1);
      chk("ill_bin",    32'(bin_out),    32'd2);
      chk("ill_pos",    32'(position),   32'd248);
      drive(3'b010);
      chk("rebase_bin", 32'(bin_out),  32'd3);
      chk("rebase_dir", 32'(dir),      32'd1);
      chk("rebase_pos", 32'(position), 32'd249);

      drive_with_clear(3'b110);
      chk("clrstep_step",   32'(step),       32'd1);
      chk("clrstep_pos",    32'(position),   32'd0);
      chk("clrstep_sticky", 32'(err_sticky), 32'd0);
      hold(1);

      drive_with_clear(3'b101);
      chk("clrerr_err",    32'(err),        32'd1);
      chk("clrerr_sticky", 32'(err_sticky), 32'd1);
      hold(2);
      chk("clrerr_hold",   32'(err_sticky), 32'd1);

      clear = 1'b1;
      hold(1);
      clear = 1'b0;
      hold(1);
      chk("lone_clr_sticky", 32'(err_sticky), 32'd0);

      drive(3'b100);
      drive(3'b000);
      drive(3'b001);
      drive(3'b011);
      drive(3'b010);
      chk("pre_rst_pos", 32'(position), 32'd5);

      // Asynchronous reset between edges must clear outputs without a clock.
      #2 rst = 1'b0;
      #1;
      chk("async_bin",    32'(bin_out),    32'd0);
      chk("async_step",   32'(step),       32'd0);
      chk("async_dir",    32'(dir),        32'd1);
      chk("async_pos",    32'(position),   32'd0);
      chk("async_err",    32'(err),        32'd0);
      chk("async_sticky", 32'(err_sticky), 32'd0);
      hold(2);
      rst = 1'b1;
      hold(8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
